// File: rtl/serial_frame_rx.sv
// ---------------------------------------------------------------------------
// serial_frame_rx
//
// Receiver for the two-wire serial link. The serial data and serial clock
// wires are synchronised into the system clock domain, and the data wire is
// sampled on each rising edge of the synchronised serial clock. Bits are
// assembled MSB first into opcode + payload + parity frames. Frames with good
// parity are pushed into a small show-ahead FIFO, which the consumer drains
// through a valid/ready handshake. Stalled partial frames are dropped after
// a timeout, and errors are reported as pulses plus a saturating counter.
//
// Ports
//   clock          system clock
//   reset_n        asynchronous, active-low reset
//   ser_data       serial data wire (asynchronous)
//   ser_clock      serial clock wire (asynchronous), data taken on its rise
//   frame_ready    consumer accepts the head frame
//   clear_err      clears overflow and err_count
//   frame_valid    FIFO holds at least one frame
//   frame_opcode   opcode of the head frame
//   frame_payload  payload of the head frame
//   fifo_count     number of frames held
//   parity_err     1-cycle pulse: frame dropped because of bad parity
//   timeout_err    1-cycle pulse: partial frame discarded after stall
//   overflow       sticky: a good frame was dropped because the FIFO was full
//   err_count      saturating count of parity and timeout errors
// ---------------------------------------------------------------------------
module serial_frame_rx #(
    parameter int OPCODE_W   = 4,
    parameter int PAYLOAD_W  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          ser_data,
    input  logic                          ser_clock,
    input  logic                          frame_ready,
    input  logic                          clear_err,
    output logic                          frame_valid,
    output logic [OPCODE_W-1:0]           frame_opcode,
    output logic [PAYLOAD_W-1:0]          frame_payload,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          timeout_err,
    output logic                          overflow,
    output logic [7:0]                    err_count
);

    localparam int FRAME_W = OPCODE_W + PAYLOAD_W + 1;
    localparam int ENTRY_W = OPCODE_W + PAYLOAD_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BCNT_W  = $clog2(FRAME_W + 1);
    localparam int IDLE_W  = $clog2(TIMEOUT + 1);

    localparam logic [BCNT_W-1:0] FRAME_LEN  = BCNT_W'(FRAME_W);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic              PAR_SENSE  = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_e;

    state_e               state_q, state_d;

    logic                 data_s1_q, data_s1_d;
    logic                 data_s2_q, data_s2_d;
    logic                 clk_s1_q, clk_s1_d;
    logic                 clk_s2_q, clk_s2_d;
    logic                 clk_prev_q, clk_prev_d;

    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic [BCNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;

    logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 parity_err_q, parity_err_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 overflow_q, overflow_d;
    logic [7:0]           err_count_q, err_count_d;

    logic                 ser_edge;
    logic                 idle_expired;
    logic                 frame_good;
    logic                 fifo_full;
    logic                 pop;
    logic                 push;
    logic                 overflow_event;
    logic                 err_event;
    logic [ENTRY_W-1:0]   head;

    assign ser_edge     = clk_s2_q & ~clk_prev_q;
    assign idle_expired = (idle_q == IDLE_LIMIT);
    assign frame_good   = ((^shreg_q) == PAR_SENSE);
    assign fifo_full    = (count_q == FIFO_FULL);
    assign pop          = frame_valid & frame_ready;

    // Two-stage synchronisers for both wires, plus one extra stage on the
    // clock wire so a rising edge can be detected in the system domain.
    always_comb begin
        data_s1_d  = ser_data;
        data_s2_d  = data_s1_q;
        clk_s1_d   = ser_clock;
        clk_s2_d   = clk_s1_q;
        clk_prev_d = clk_s2_q;
    end

    // State register and all other flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            data_s1_q     <= 1'b0;
            data_s2_q     <= 1'b0;
            clk_s1_q      <= 1'b0;
            clk_s2_q      <= 1'b0;
            clk_prev_q    <= 1'b0;
            shreg_q       <= '0;
            bitcnt_q      <= '0;
            idle_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            parity_err_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            overflow_q    <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            data_s1_q     <= data_s1_d;
            data_s2_q     <= data_s2_d;
            clk_s1_q      <= clk_s1_d;
            clk_s2_q      <= clk_s2_d;
            clk_prev_q    <= clk_prev_d;
            shreg_q       <= shreg_d;
            bitcnt_q      <= bitcnt_d;
            idle_q        <= idle_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            parity_err_q  <= parity_err_d;
            timeout_err_q <= timeout_err_d;
            overflow_q    <= overflow_d;
            err_count_q   <= err_count_d;
        end
    end

    // Next-state logic: frame assembly, bit counting and stall detection.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        idle_d   = idle_q;
        case (state_q)
            IDLE: begin
                idle_d = '0;
                if (ser_edge) begin
                    shreg_d  = {{(FRAME_W-1){1'b0}}, data_s2_q};
                    bitcnt_d = BCNT_W'(1);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_edge) begin
                    shreg_d  = {shreg_q[FRAME_W-2:0], data_s2_q};
                    bitcnt_d = bitcnt_q + BCNT_W'(1);
                    idle_d   = '0;
                    if (bitcnt_q + BCNT_W'(1) == FRAME_LEN) begin
                        state_d = CHECK;
                    end
                end else if (idle_expired) begin
                    shreg_d  = '0;
                    bitcnt_d = '0;
                    idle_d   = '0;
                    state_d  = IDLE;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            CHECK: begin
                // The frame stays in shreg_q for this cycle. An edge seen
                // here starts the next frame so no bit is lost.
                idle_d   = '0;
                bitcnt_d = '0;
                if (ser_edge) begin
                    shreg_d  = {{(FRAME_W-1){1'b0}}, data_s2_q};
                    bitcnt_d = BCNT_W'(1);
                    state_d  = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: error pulses and the push/overflow decision. A full
    // FIFO still accepts a push when the consumer pops in the same cycle.
    always_comb begin
        push           = 1'b0;
        parity_err_d   = 1'b0;
        timeout_err_d  = 1'b0;
        overflow_event = 1'b0;
        case (state_q)
            SHIFT: begin
                timeout_err_d = ~ser_edge & idle_expired;
            end
            CHECK: begin
                if (!frame_good) begin
                    parity_err_d = 1'b1;
                end else if (!fifo_full || pop) begin
                    push = 1'b1;
                end else begin
                    overflow_event = 1'b1;
                end
            end
            default: begin
                push = 1'b0;
            end
        endcase
    end

    // FIFO storage and pointers; the parity bit is not stored.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = shreg_q[FRAME_W-1:1];
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Error bookkeeping. A clear in the same cycle as an event keeps that
    // cycle's event rather than losing it.
    always_comb begin
        err_event = parity_err_d | timeout_err_d;
        if (clear_err) begin
            err_count_d = err_event ? 8'd1 : 8'd0;
            overflow_d  = overflow_event;
        end else begin
            err_count_d = err_count_q;
            if (err_event && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end
            overflow_d = overflow_q | overflow_event;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign frame_valid   = (count_q != '0);
    assign frame_opcode  = head[ENTRY_W-1 -: OPCODE_W];
    assign frame_payload = head[PAYLOAD_W-1:0];
    assign fifo_count    = count_q;
    assign parity_err    = parity_err_q;
    assign timeout_err   = timeout_err_q;
    assign overflow      = overflow_q;
    assign err_count     = err_count_q;

endmodule
